// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event decoder.
package button_event_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} btn_state_t;

  // 64-bit intermediate so large clock frequencies times milliseconds do not overflow.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    longint unsigned cycles;
    cycles = (64'(clk_freq) * 64'(ms)) / 64'd1000;
    return 32'(cycles);
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable up-counter with a terminal-match flag against a runtime compare value.
module hold_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             incr,
  input  logic [Width-1:0] cmp_val,
  output logic             match
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (incr) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign match = (cnt_q == cmp_val);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat strobes plus a held level.
// Auto-repeat in the long-press state is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned clk_freq  = 25_000_000,
  parameter int unsigned long_ms   = 1000,
  parameter int unsigned repeat_ms = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned long_cycles = ms_to_cycles(clk_freq, long_ms);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned repeat_cycles = ms_to_cycles(clk_freq, repeat_ms);
  localparam int unsigned max_cycles    =
      (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
`else
  localparam int unsigned unused_repeat_ms = repeat_ms;
  localparam int unsigned max_cycles       = long_cycles;
`endif
  localparam int unsigned cnt_w = $clog2(max_cycles);

  if (long_cycles < 2) begin : g_long_check
    $error("button_event_decoder: long_cycles must be >= 2");
  end

  localparam logic [cnt_w-1:0] long_cmp = cnt_w'(long_cycles - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  if (repeat_cycles < 1) begin : g_repeat_check
    $error("button_event_decoder: repeat_cycles must be >= 1");
  end

  localparam logic [cnt_w-1:0] repeat_cmp = cnt_w'(repeat_cycles - 1);
  logic repeat_d;
`endif

  btn_state_t       state_q, state_d;
  logic             cnt_load, cnt_incr, cnt_match;
  logic [cnt_w-1:0] cmp_val;
  logic             press_d, release_d, long_d;

  hold_counter #(
    .Width (cnt_w)
  ) u_hold_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ('0),
    .incr     (cnt_incr),
    .cmp_val  (cmp_val),
    .match    (cnt_match)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_incr  = 1'b0;
    cmp_val   = long_cmp;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (btn_level) begin
          state_d  = PRESSED;
          cnt_load = 1'b1;
          press_d  = 1'b1;
        end
      end
      PRESSED: begin
        // Release wins over reaching the long threshold in the same cycle.
        if (!btn_level) begin
          state_d   = IDLE;
          cnt_load  = 1'b1;
          release_d = 1'b1;
        end else if (cnt_match) begin
          state_d  = LONG;
          cnt_load = 1'b1;
          long_d   = 1'b1;
        end else begin
          cnt_incr = 1'b1;
        end
      end
      LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        cmp_val = repeat_cmp;
`endif
        if (!btn_level) begin
          state_d   = IDLE;
          cnt_load  = 1'b1;
          release_d = 1'b1;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (cnt_match) begin
          cnt_load = 1'b1;
          repeat_d = 1'b1;
        end else begin
          cnt_incr = 1'b1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      held          <= (state_d != IDLE);
`ifdef BUTTON_AUTO_REPEAT_EN
      repeat_pulse  <= repeat_d;
`endif
    end
  end

`ifndef BUTTON_AUTO_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed-vector bench for button_event_decoder at 1 cycle per ms (long=10, repeat=4).
module tb_button_event_decoder;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  always #5 clk = ~clk;

  button_event_decoder #(
    .clk_freq  (1000),
    .long_ms   (10),
    .repeat_ms (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  // Expected outputs packed as {press, release, long, repeat, held}.
  typedef struct {
    string      name;
    logic       rst;
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string name, input logic rst, input logic btn,
                     input logic [4:0] exp);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.btn  = btn;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Drive inputs before an edge, then sample 1 time unit after it.
  task automatic step(input string name, input logic rst, input logic btn,
                      input logic [4:0] exp);
    logic [4:0] act;
    reset     = rst;
    btn_level = btn;
    @(posedge clk);
    #1;
    act = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got p/r/l/rp/h=%b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic rp;
    reset     = 1'b1;
    btn_level = 1'b0;

    add("reset0", 1'b1, 1'b0, 5'b00000);
    add("reset1", 1'b1, 1'b0, 5'b00000);
    add("idle0",  1'b0, 1'b0, 5'b00000);
    add("idle1",  1'b0, 1'b0, 5'b00000);

    for (int i = 0; i < 5; i++)
      add($sformatf("short[%0d]", i), 1'b0, 1'b1, {i == 0, 1'b0, 1'b0, 1'b0, 1'b1});
    add("short_rel",  1'b0, 1'b0, 5'b01000);
    add("short_idle", 1'b0, 1'b0, 5'b00000);

    add("one_press", 1'b0, 1'b1, 5'b10001);
    add("one_rel",   1'b0, 1'b0, 5'b01000);
    add("one_idle",  1'b0, 1'b0, 5'b00000);

    for (int i = 0; i < 25; i++) begin
      rp = RepEn && (i >= 14) && (((i - 14) % 4) == 0);
      add($sformatf("long[%0d]", i), 1'b0, 1'b1, {i == 0, 1'b0, i == 10, rp, 1'b1});
    end
    add("long_rel",  1'b0, 1'b0, 5'b01000);
    add("long_idle", 1'b0, 1'b0, 5'b00000);

    foreach (vecs[k]) step(vecs[k].name, vecs[k].rst, vecs[k].btn, vecs[k].exp);

    // Release lands on the edge where the long threshold would fire.
    for (int i = 0; i < 10; i++)
      step($sformatf("thr[%0d]", i), 1'b0, 1'b1, {i == 0, 1'b0, 1'b0, 1'b0, 1'b1});
    step("thr_rel",  1'b0, 1'b0, 5'b01000);
    step("thr_idle", 1'b0, 1'b0, 5'b00000);
    // Counter must have restarted: a fresh hold reaches long after exactly 10 edges.
    for (int i = 0; i <= 10; i++)
      step($sformatf("thr_again[%0d]", i), 1'b0, 1'b1, {i == 0, 1'b0, i == 10, 1'b0, 1'b1});
    step("thr_again_rel", 1'b0, 1'b0, 5'b01000);

    // Reset in the middle of a long hold: silent clear, then re-press on exit.
    for (int i = 0; i < 12; i++)
      step($sformatf("mid[%0d]", i), 1'b0, 1'b1, {i == 0, 1'b0, i == 10, 1'b0, 1'b1});
    step("rst_mid",   1'b1, 1'b1, 5'b00000);
    step("rst_hold",  1'b1, 1'b1, 5'b00000);
    step("rst_exit",  1'b0, 1'b1, 5'b10001);
    step("rst_exit2", 1'b0, 1'b1, 5'b00001);
    step("rst_rel",   1'b0, 1'b0, 5'b01000);
    step("rst_idle",  1'b0, 1'b0, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
